// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and the FSM state type for the UART echo
//               responder (uart_responder and its FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } resp_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_responder_fifo
// Description : Synchronous single-clock FIFO buffering received bytes.
//               The read port is fall-through: pop_data shows the oldest
//               entry whenever empty is low, and pop advances past it.
//               Full is evaluated on the pre-pop count, so a push and a pop
//               in the same cycle while full still rejects the push.
// Ports       : clk       - clock
//               rst_n     - synchronous active-low reset
//               push      - write push_data (ignored when full)
//               push_data - byte to store
//               pop       - discard oldest entry (ignored when empty)
//               pop_data  - oldest entry
//               full      - DEPTH entries held
//               empty     - no entries held
//               count     - number of entries held (0..DEPTH)
// Parameters  : DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_responder_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_responder_fifo
`default_nettype wire

// File: rtl/uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_responder
// Description : Echoes every byte received from a UART receiver back to a
//               UART transmitter, in arrival order, through a FIFO.
//               A registered rising-edge detect on rx_ready produces one
//               push per byte; a four-state sequencer hands bytes to the
//               transmitter with a one-cycle start pulse and watches tx_done
//               go low (busy) then high (finished). A watchdog abandons a
//               byte whose transmitter never answers.
// Ports       : clk           - clock, all logic on posedge
//               rst_n         - synchronous active-low reset
//               rx_ready      - receiver byte valid (pulse or level)
//               rx_data       - received byte
//               tx_data       - byte to transmitter, stable for whole byte
//               tx_data_ready - one-cycle start pulse to transmitter
//               tx_done       - transmitter idle level (low while shifting)
//               fifo_count    - bytes currently buffered
//               overflow      - sticky, a byte was dropped on a full FIFO
//               tx_timeout    - one-cycle pulse, byte abandoned
// Macro       : UART_RESPONDER_CRLF_EN - when defined, every completed CR
//               (8'h0D) is followed by an inserted LF (8'h0A) that does not
//               come from, or change, the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_responder
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_ready,
    input  logic [BYTE_W-1:0]             rx_data,
    output logic [BYTE_W-1:0]             tx_data,
    output logic                          tx_data_ready,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_timeout
);

    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TX_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Receive side: edge detect and push
    // ------------------------------------------------------------------
    // r_rx_low remembers that rx_ready was seen low. It clears on reset, so
    // an rx_ready already high when reset releases must drop first.
    logic              r_rx_low;
    logic              r_push;
    logic [BYTE_W-1:0] r_push_data;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic [BYTE_W-1:0] w_fifo_data;
    logic              w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_low    <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_low    <= !rx_ready;
            r_push      <= rx_ready && r_rx_low;
            r_push_data <= rx_data;
            if (r_push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign overflow = r_overflow;

    uart_responder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------
    resp_state_t       r_state;
    resp_state_t       w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [BYTE_W-1:0] r_tx_data;

    logic              w_load;
    logic [BYTE_W-1:0] w_load_data;
    logic              w_tmr_run;
    logic              w_tmr_hit;
    logic              w_start;
    logic              w_timeout;

`ifdef UART_RESPONDER_CRLF_EN
    logic              r_lf_pending;
    logic              w_lf_set;
    logic              w_lf_clr;
`endif

    assign w_tmr_hit = (r_timer == C_TMR_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_data = w_fifo_data;
        w_tmr_run   = 1'b0;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
`ifdef UART_RESPONDER_CRLF_EN
        w_lf_set    = 1'b0;
        w_lf_clr    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
`ifdef UART_RESPONDER_CRLF_EN
                // A pending LF goes out before any buffered byte.
                if (r_lf_pending) begin
                    if (tx_done) begin
                        w_load      = 1'b1;
                        w_load_data = CHAR_LF;
                        w_lf_clr    = 1'b1;
                        w_state_nxt = START;
                    end
                end else
`endif
                if (!w_empty && tx_done) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_start     = 1'b1;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Watchdog first, so the timer never runs past its limit.
                if (w_tmr_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_run = 1'b1;
                    if (!tx_done) begin
                        w_state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // A byte that finishes on the last allowed cycle counts as
                // sent, not abandoned.
                if (tx_done) begin
                    w_state_nxt = IDLE;
`ifdef UART_RESPONDER_CRLF_EN
                    w_lf_set    = (r_tx_data == CHAR_CR);
`endif
                end else if (w_tmr_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_tmr_run ? r_timer + 1'b1 : '0;
            // tx_data only moves on the IDLE->START transition.
            if (w_load) begin
                r_tx_data <= w_load_data;
            end
        end
    end

`ifdef UART_RESPONDER_CRLF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lf_pending <= 1'b0;
        end else if (w_lf_set) begin
            r_lf_pending <= 1'b1;
        end else if (w_lf_clr) begin
            r_lf_pending <= 1'b0;
        end
    end
`else
    // Bytes are sent verbatim; no LF tracking exists in this build.
`endif

    assign tx_data       = r_tx_data;
    assign tx_data_ready = w_start;
    assign tx_timeout    = w_timeout;

endmodule : uart_responder
`default_nettype wire

// File: tb/tb_uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_responder
// Description : Directed self-checking bench for uart_responder with a
//               simple transmitter model (busy for a fixed time, can be
//               forced busy or made non-responding).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_responder;

    localparam int FIFO_DEPTH = 16;
    localparam int TX_TIMEOUT = 64;
    localparam int BUSY_CYC   = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_data_ready;
    logic        tx_done;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        tx_timeout;

    int          n_checks = 0;
    int          n_errors = 0;

    // Transmitter model state
    logic        tx_idle   = 1'b1;
    logic        hold_low  = 1'b0;
    logic        tx_dead   = 1'b0;
    int          busy_cnt  = 0;
    int          n_starts  = 0;
    int          stab_err  = 0;
    logic [7:0]  cap       = 8'h00;
    logic [7:0]  got_q[$];

    always #5 clk = ~clk;

    uart_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .tx_done       (tx_done),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .tx_timeout    (tx_timeout)
    );

    assign tx_done = tx_idle && !hold_low;

    always @(posedge clk) begin
        if (tx_data_ready) begin
            n_starts++;
            got_q.push_back(tx_data);
            cap = tx_data;
            if (!tx_dead) begin
                busy_cnt = BUSY_CYC;
                tx_idle <= 1'b0;
            end
        end else if (busy_cnt > 0) begin
            if (tx_data !== cap) stab_err++;
            busy_cnt--;
            if (busy_cnt == 0) tx_idle <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_ready(input int max, output int n, output logic [7:0] d);
        n = -1;
        d = 8'hxx;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (tx_data_ready) begin
                n = i;
                d = tx_data;
                break;
            end
        end
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (got_q.size() > idx) return got_q[idx];
        return 8'hxx;
    endfunction

    initial begin
        int         n;
        int         s0;
        int         t;
        logic [7:0] d;
        logic [7:0] exp_seq [3];
        int         exp_n;

        // Reset with rx_ready already high
        rst_n    = 1'b0;
        rx_ready = 1'b1;
        rx_data  = 8'h77;
        repeat (3) @(negedge clk);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_data_ready", tx_data_ready, 0);
        check("rst_tx_timeout", tx_timeout, 0);
        check("rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("held_rx_no_push", fifo_count, 0);
        check("held_rx_no_start", n_starts, 0);
        rx_ready = 1'b0;
        @(negedge clk);

        // Single byte, latency
        got_q.delete();
        s0 = n_starts;
        send_pulse(8'h63);
        wait_ready(10, n, d);
        check("single_latency", n + 1, 3);
        check("single_tx_data", d, 8'h63);
        repeat (20) @(negedge clk);
        check("single_starts", n_starts - s0, 1);
        check("single_fifo_empty", fifo_count, 0);

        // rx_ready held high for 50 cycles
        got_q.delete();
        s0 = n_starts;
        @(negedge clk);
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        repeat (50) @(negedge clk);
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("held_starts", n_starts - s0, 1);
        check("held_data", got_at(0), 8'hA5);
        check("held_fifo_empty", fifo_count, 0);

        // Burst of 20 into a 16-deep FIFO with the transmitter held busy
        got_q.delete();
        s0 = n_starts;
        hold_low = 1'b1;
        for (int i = 0; i < 20; i++) send_pulse(8'(i));
        repeat (2) @(negedge clk);
        check("burst_fifo_full", fifo_count, FIFO_DEPTH);
        check("burst_overflow", overflow, 1);
        hold_low = 1'b0;
        repeat (300) @(negedge clk);
        check("burst_starts", n_starts - s0, 16);
        for (int i = 0; i < 16; i++) check($sformatf("burst_byte%0d", i), got_at(i), i);
        check("burst_tx_stable", stab_err, 0);
        check("burst_fifo_empty", fifo_count, 0);
        check("burst_overflow_sticky", overflow, 1);

        // Reset during WAIT_DONE with 3 bytes buffered
        s0 = n_starts;
        send_pulse(8'h31);
        send_pulse(8'h32);
        send_pulse(8'h33);
        send_pulse(8'h34);
        repeat (2) @(negedge clk);
        check("pre_reset_count", fifo_count, 3);
        check("pre_reset_busy", tx_done, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ready", tx_data_ready, 0);
        check("mid_rst_overflow", overflow, 0);
        repeat (40) @(negedge clk);
        check("mid_rst_no_more_starts", n_starts - s0, 1);

        // Non-responding transmitter: timeout after 64 cycles
        got_q.delete();
        tx_dead = 1'b1;
        send_pulse(8'h11);
        wait_ready(10, n, d);
        check("to_first_data", d, 8'h11);
        t = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 2) begin
                rx_data  = 8'h22;
                rx_ready = 1'b1;
            end
            if (i == 3) rx_ready = 1'b0;
            if (tx_timeout) begin
                t = i;
                break;
            end
        end
        check("to_first_delay", t, TX_TIMEOUT);
        @(negedge clk);
        check("to_pulse_width", tx_timeout, 0);
        wait_ready(10, n, d);
        check("to_next_start", n, 1);
        check("to_next_data", d, 8'h22);
        t = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (tx_timeout) begin
                t = i;
                break;
            end
        end
        check("to_second_delay", t, TX_TIMEOUT);
        tx_dead = 1'b0;
        repeat (5) @(negedge clk);
        check("to_fifo_empty", fifo_count, 0);

        // CR handling
`ifdef UART_RESPONDER_CRLF_EN
        exp_seq[0] = 8'h0D; exp_seq[1] = 8'h0A; exp_seq[2] = 8'h41; exp_n = 3;
`else
        exp_seq[0] = 8'h0D; exp_seq[1] = 8'h41; exp_seq[2] = 8'h00; exp_n = 2;
`endif
        got_q.delete();
        s0 = n_starts;
        stab_err = 0;
        send_pulse(8'h0D);
        send_pulse(8'h41);
        repeat (80) @(negedge clk);
        check("cr_starts", n_starts - s0, exp_n);
        for (int i = 0; i < exp_n; i++) check($sformatf("cr_byte%0d", i), got_at(i), exp_seq[i]);
        check("cr_fifo_empty", fifo_count, 0);
        check("cr_tx_stable", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_responder
`default_nettype wire
